// File: rtl/shift_logic.sv
// shift_logic: registered logical barrel shifter, left or right with zero fill.
// Result, valid and zero flags feed writeback and branch logic.
`timescale 1ns/1ps
module shift_logic #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             left,
    input  logic [WIDTH-1:0] regis,
    input  logic [SHW-1:0]   samt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_zero
);

    logic [WIDTH-1:0] stg [0:SHW];
    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    assign stg[0] = regis;

    // One mux level per samt bit, shifting by 2**k.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stg[k+1] = !samt[k] ? stg[k] :
                          left     ? (stg[k] << SH) :
                                     (stg[k] >> SH);
    end

    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = stg[SHW];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_zero  = (out_q == '0);

endmodule

// File: tb/tb_shift_logic.sv
// tb_shift_logic: scoreboard bench for shift_logic.
// Stimulus pushes expected results; a monitor pops them on out_valid.
`timescale 1ns/1ps
module tb_shift_logic;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        left;
    logic [31:0] regis;
    logic [4:0]  samt;
    logic [31:0] out;
    logic        out_valid;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] held;
    bit          mon_en;

    shift_logic #(.WIDTH(32), .SHW(5)) dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .left      (left),
        .regis     (regis),
        .samt      (samt),
        .out       (out),
        .out_valid (out_valid),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample in_valid at the edge, compare outputs 1 ns later.
    always @(posedge clk) begin
        logic iv;
        logic [31:0] e;
        iv = in_valid;
        #1;
        if (rst_n && mon_en) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, iv});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", out, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("out", out, e);
                    check("out_zero", {31'b0, out_zero},
                          {31'b0, (e == 32'h0)});
                    held = e;
                end
            end else begin
                check("hold", out, held);
            end
        end
    end

    task automatic op(input logic l,
                      input logic [31:0] r,
                      input logic [4:0] s,
                      input logic [31:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        left     = l;
        regis    = r;
        samt     = s;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        left     = 1'($urandom);
        regis    = $urandom;
        samt     = 5'($urandom);
    endtask

    task automatic reset_check();
        check("rst_out", out, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_zero", {31'b0, out_zero}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        l;
        logic [31:0] r;
        logic [4:0]  s;
        mon_en   = 1'b0;
        held     = 32'h0;
        in_valid = 1'b0;
        left     = 1'b0;
        regis    = 32'h0;
        samt     = 5'h0;
        rst_n    = 1'b0;
        #5;
        reset_check();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        op(1'b1, 32'h5, 5'd1, 32'h0000_000A);
        op(1'b0, 32'h5, 5'd1, 32'h0000_0002);
        op(1'b1, 32'h5, 5'd4, 32'h0000_0050);
        op(1'b0, 32'h5, 5'd4, 32'h0000_0000);

        op(1'b1, 32'h8000_0001, 5'd0,  32'h8000_0001);
        op(1'b0, 32'h8000_0001, 5'd0,  32'h8000_0001);
        op(1'b1, 32'h8000_0001, 5'd31, 32'h8000_0000);
        op(1'b0, 32'h8000_0001, 5'd31, 32'h0000_0001);
        op(1'b1, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00);
        op(1'b0, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD);

        op(1'b1, 32'h0000_00F0, 5'd3, 32'h0000_0780);
        repeat (3) idle();

        // Mid-stream async reset, away from any clock edge.
        op(1'b1, 32'h1234_5678, 5'd4, 32'h2345_6780);
        idle();
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        reset_check();
        exp_q.delete();
        held = 32'h0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle();

        for (int i = 0; i < 1000; i++) begin
            l = 1'($urandom);
            r = $urandom;
            s = 5'($urandom);
            op(l, r, s, l ? (r << s) : (r >> s));
        end
        idle();
        idle();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
